bh1750_sequencer: RTL and testbench

- Controls the BH1750FVI ambient-light sensor over an external byte-level I2C master.
- Sequence: power-up wait, POWER_ON, RESET, mode command, measurement wait, then a 2-byte result read.
- Delivers the 16-bit raw count with a one-cycle valid pulse to the downstream lux scaling stage.
- Supports continuous and single-shot operation, with NACK error capture and automatic retry.

---
 rtl/bh1750_sequencer_pkg.sv | 31 +++
 rtl/bh1750_sequencer.sv | 154 +++++++++++++++
 tb/tb_bh1750_sequencer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bh1750_sequencer_pkg.sv
// Shared definitions for the BH1750FVI ambient-light sensor sequencer:
// command bytes, state encoding and default timing at a 12 MHz clock.
package bh1750_sequencer_pkg;

    localparam logic [7:0] CMD_PWRON  = 8'h01;
    localparam logic [7:0] CMD_RESET  = 8'h07;
    localparam logic [7:0] CMD_CHRES  = 8'h10;
    localparam logic [7:0] CMD_OTHRES = 8'h20;

    localparam int DEF_PWRUP_CYC = 12000;
    localparam int DEF_MEAS_CYC  = 2160000;
    localparam int DEF_RETRY_CYC = 120000;

    typedef enum logic [3:0] {
        PWR_WAIT  = 4'd0,
        S_PWRON   = 4'd1,
        S_RESET   = 4'd2,
        IDLE      = 4'd3,
        S_MODE    = 4'd4,
        WAIT_MEAS = 4'd5,
        S_READ    = 4'd6,
        BACKOFF   = 4'd7
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/bh1750_sequencer.sv
// BH1750FVI sequencer: power-up, POWER_ON/RESET/mode commands, measurement
// wait and 2-byte result read through an external byte-level I2C master.
//
// state     | meaning
// PWR_WAIT  | post-reset settle before the first command
// S_PWRON   | writing POWER_ON (0x01)
// S_RESET   | writing RESET (0x07)
// IDLE      | sensor configured, waiting for continuous mode or a start
// S_MODE    | writing 0x10 (continuous H-res) or 0x20 (one-time H-res)
// WAIT_MEAS | waiting out the conversion time
// S_READ    | reading the 16-bit result
// BACKOFF   | pause after a NACK before restarting at POWER_ON
module bh1750_sequencer
    import bh1750_sequencer_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR  = 7'h23,
    parameter int         PWRUP_CYC = DEF_PWRUP_CYC,
    parameter int         MEAS_CYC  = DEF_MEAS_CYC,
    parameter int         RETRY_CYC = DEF_RETRY_CYC
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        cont_mode,
    input  logic        start,
    output logic        i2c_req,
    output logic        i2c_rd,
    output logic [6:0]  i2c_addr,
    output logic [7:0]  i2c_wdata,
    input  logic        i2c_done,
    input  logic        i2c_nack,
    input  logic [15:0] i2c_rdata,
    output logic [15:0] lux_raw,
    output logic        lux_valid,
    output logic        busy,
    output logic        err
);

    localparam int CNT_LOG = $clog2(max3(PWRUP_CYC, MEAS_CYC, RETRY_CYC));
    localparam int CNT_W   = (CNT_LOG > 0) ? CNT_LOG : 1;

    localparam logic [CNT_W-1:0] PWRUP_TC = CNT_W'(PWRUP_CYC - 1);
    localparam logic [CNT_W-1:0] MEAS_TC  = CNT_W'(MEAS_CYC - 1);
    localparam logic [CNT_W-1:0] RETRY_TC = CNT_W'(RETRY_CYC - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             mode_cont;   // mode actually programmed into the sensor
    logic             powered;     // sensor is awake and accepts a mode command
    logic             shot_pend;   // single-shot start accepted, not yet sent

    assign i2c_addr = DEV_ADDR;

    task automatic go(input state_t nxt);
        state <= nxt;
        cnt   <= '0;
        busy  <= (nxt != IDLE);
    endtask

    task automatic go_cmd(input state_t nxt, input logic rd, input logic [7:0] byte_val);
        go(nxt);
        i2c_rd    <= rd;
        i2c_wdata <= byte_val;
    endtask

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state     <= PWR_WAIT;
            cnt       <= '0;
            i2c_req   <= 1'b0;
            i2c_rd    <= 1'b0;
            i2c_wdata <= 8'h00;
            lux_raw   <= 16'h0000;
            lux_valid <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            mode_cont <= 1'b0;
            powered   <= 1'b0;
            shot_pend <= 1'b0;
        end else begin
            cnt       <= cnt + 1'b1;
            lux_valid <= 1'b0;
            busy      <= (state != IDLE);

            case (state)
                PWR_WAIT: begin
                    if (cnt == PWRUP_TC)
                        go_cmd(S_PWRON, 1'b0, CMD_PWRON);
                end

                S_PWRON, S_RESET, S_MODE, S_READ: begin
                    // Request rises one cycle after entry so it always drops
                    // for at least a cycle between back-to-back transactions.
                    if (i2c_req && i2c_done) begin
                        i2c_req <= 1'b0;
                        if (i2c_nack) begin
                            err     <= 1'b1;
                            powered <= 1'b0;
                            go(BACKOFF);
                        end else begin
                            case (state)
                                S_PWRON: go_cmd(S_RESET, 1'b0, CMD_RESET);
                                S_RESET: begin
                                    powered <= 1'b1;
                                    go(IDLE);
                                end
                                S_MODE:  go(WAIT_MEAS);
                                default: begin
                                    lux_raw   <= i2c_rdata;
                                    lux_valid <= 1'b1;
                                    err       <= 1'b0;
                                    if (mode_cont && cont_mode) begin
                                        go(WAIT_MEAS);
                                    end else begin
                                        // one-time mode powers the sensor down
                                        powered <= mode_cont;
                                        go(IDLE);
                                    end
                                end
                            endcase
                        end
                    end else if (!i2c_req && cnt == '0) begin
                        i2c_req <= 1'b1;
                    end
                end

                IDLE: begin
                    if (cont_mode || start || shot_pend) begin
                        if (powered) begin
                            mode_cont <= cont_mode;
                            shot_pend <= 1'b0;
                            go_cmd(S_MODE, 1'b0, cont_mode ? CMD_CHRES : CMD_OTHRES);
                        end else begin
                            shot_pend <= ~cont_mode;
                            go_cmd(S_PWRON, 1'b0, CMD_PWRON);
                        end
                    end
                end

                WAIT_MEAS: begin
                    if (cnt == MEAS_TC)
                        go_cmd(S_READ, 1'b1, 8'h00);
                end

                BACKOFF: begin
                    if (cnt == RETRY_TC)
                        go_cmd(S_PWRON, 1'b0, CMD_PWRON);
                end

                default: go(PWR_WAIT);
            endcase
        end
    end

endmodule

// File: tb/tb_bh1750_sequencer.sv
// Directed bench for bh1750_sequencer with a stubbed byte-level I2C master
// answering two cycles after each request.
module tb_bh1750_sequencer;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        cont_mode;
    logic        start;
    logic        i2c_req;
    logic        i2c_rd;
    logic [6:0]  i2c_addr;
    logic [7:0]  i2c_wdata;
    logic        i2c_done;
    logic        i2c_nack;
    logic [15:0] i2c_rdata;
    logic [15:0] lux_raw;
    logic        lux_valid;
    logic        busy;
    logic        err;

    bh1750_sequencer #(
        .DEV_ADDR (7'h23),
        .PWRUP_CYC(10),
        .MEAS_CYC (50),
        .RETRY_CYC(20)
    ) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .cont_mode(cont_mode),
        .start    (start),
        .i2c_req  (i2c_req),
        .i2c_rd   (i2c_rd),
        .i2c_addr (i2c_addr),
        .i2c_wdata(i2c_wdata),
        .i2c_done (i2c_done),
        .i2c_nack (i2c_nack),
        .i2c_rdata(i2c_rdata),
        .lux_raw  (lux_raw),
        .lux_valid(lux_valid),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // I2C master stub; reads are logged as 9'h100, writes as {0, byte}
    logic [7:0]  nack_byte = 8'h00;
    int          nack_left = 0;
    logic [15:0] rd_val    = 16'h0000;
    logic [8:0]  tx_log[$];
    int          tx_det[$];
    int          tx_done[$];

    initial begin
        i2c_done  = 1'b0;
        i2c_nack  = 1'b0;
        i2c_rdata = 16'h0000;
        forever begin
            @(posedge clk_in); #1;
            if (i2c_req) begin
                tx_log.push_back({i2c_rd, i2c_rd ? 8'h00 : i2c_wdata});
                tx_det.push_back(cyc);
                repeat (2) @(posedge clk_in);
                #1;
                i2c_done  = 1'b1;
                i2c_nack  = (!i2c_rd && nack_left > 0 && i2c_wdata == nack_byte);
                if (i2c_nack) nack_left--;
                i2c_rdata = rd_val;
                tx_done.push_back(cyc);
                @(posedge clk_in); #1;
                i2c_done = 1'b0;
                i2c_nack = 1'b0;
            end
        end
    end

    int   n_valid  = 0;
    int   multi_v  = 0;
    logic prev_v   = 1'b0;
    logic err_seen = 1'b0;
    int   valid_cyc[$];

    always @(negedge clk_in) begin
        if (lux_valid) begin
            n_valid++;
            valid_cyc.push_back(cyc);
            if (prev_v) multi_v++;
        end
        prev_v = lux_valid;
        if (err) err_seen = 1'b1;
    end

    int rel_cyc = 0;

    task automatic hold_reset(input logic cm);
        rst_in    = 1'b1;
        cont_mode = cm;
        start     = 1'b0;
        repeat (5) @(posedge clk_in);
        #2;
        tx_log.delete();
        tx_det.delete();
        tx_done.delete();
        valid_cyc.delete();
        n_valid  = 0;
        err_seen = 1'b0;
        rst_in   = 1'b0;
        rel_cyc  = cyc;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk_in); #2;
        start = 1'b0;
    endtask

    initial begin
        rst_in    = 1'b1;
        cont_mode = 1'b1;
        start     = 1'b0;
        rd_val    = 16'h1234;
        #2;
        check_val("rst_req",   32'(i2c_req),   32'h0);
        check_val("rst_rd",    32'(i2c_rd),    32'h0);
        check_val("rst_wdata", 32'(i2c_wdata), 32'h0);
        check_val("rst_lux",   32'(lux_raw),   32'h0);
        check_val("rst_valid", 32'(lux_valid), 32'h0);
        check_val("rst_busy",  32'(busy),      32'h0);
        check_val("rst_err",   32'(err),       32'h0);
        check_val("addr",      32'(i2c_addr),  32'h23);

        // continuous mode
        hold_reset(1'b1);
        @(posedge clk_in); #2;
        check_val("busy_pwr_wait", 32'(busy), 32'h1);
        for (int i = 0; i < 1000 && n_valid < 3; i++) begin
            @(posedge clk_in); #2;
        end
        check_val("cont_nvalid", 32'(n_valid), 32'd3);
        check_val("cont_ntx", 32'(tx_log.size()), 32'd6);
        check_val("cont_tx0", 32'(tx_log[0]), 32'h001);
        check_val("cont_tx1", 32'(tx_log[1]), 32'h007);
        check_val("cont_tx2", 32'(tx_log[2]), 32'h010);
        check_val("cont_tx3", 32'(tx_log[3]), 32'h100);
        check_val("cont_tx5", 32'(tx_log[5]), 32'h100);
        check_val("cont_pwrup_lat", 32'(tx_det[0] - rel_cyc), 32'd11);
        check_val("cont_lux", 32'(lux_raw), 32'h1234);
        check_val("cont_first_lat", 32'(valid_cyc[0] - tx_done[2]), 32'd55);
        check_val("cont_period", 32'(valid_cyc[1] - valid_cyc[0]), 32'd54);
        check_val("cont_err", 32'(err), 32'h0);

        // single-shot
        rd_val = 16'hABCD;
        hold_reset(1'b0);
        for (int i = 0; i < 200 && !(tx_log.size() >= 2 && !busy); i++) begin
            @(posedge clk_in); #2;
        end
        check_val("ss_init_ntx", 32'(tx_log.size()), 32'd2);
        check_val("ss_idle_busy", 32'(busy), 32'h0);
        pulse_start();
        for (int i = 0; i < 300 && !(n_valid >= 1 && !busy); i++) begin
            @(posedge clk_in); #2;
        end
        repeat (100) @(posedge clk_in);
        #2;
        check_val("ss_ntx", 32'(tx_log.size()), 32'd4);
        check_val("ss_tx2", 32'(tx_log[2]), 32'h020);
        check_val("ss_tx3", 32'(tx_log[3]), 32'h100);
        check_val("ss_nvalid", 32'(n_valid), 32'd1);
        check_val("ss_lux", 32'(lux_raw), 32'hABCD);
        check_val("ss_busy", 32'(busy), 32'h0);

        // second shot powers up again; starts during the wait are ignored
        rd_val = 16'h4321;
        pulse_start();
        for (int i = 0; i < 200 && tx_done.size() < 7; i++) begin
            @(posedge clk_in); #2;
        end
        repeat (5) @(posedge clk_in);
        #2;
        pulse_start();
        repeat (3) @(posedge clk_in);
        #2;
        pulse_start();
        for (int i = 0; i < 300 && !(n_valid >= 2 && !busy); i++) begin
            @(posedge clk_in); #2;
        end
        repeat (150) @(posedge clk_in);
        #2;
        check_val("ss2_ntx", 32'(tx_log.size()), 32'd8);
        check_val("ss2_tx4", 32'(tx_log[4]), 32'h001);
        check_val("ss2_tx5", 32'(tx_log[5]), 32'h007);
        check_val("ss2_tx6", 32'(tx_log[6]), 32'h020);
        check_val("ss2_nvalid", 32'(n_valid), 32'd2);
        check_val("ss2_lux", 32'(lux_raw), 32'h4321);

        // NACK on RESET, back-off and recovery
        rd_val    = 16'h5678;
        nack_byte = 8'h07;
        nack_left = 1;
        hold_reset(1'b1);
        for (int i = 0; i < 600 && n_valid < 1; i++) begin
            @(posedge clk_in); #2;
        end
        check_val("nack_nvalid", 32'(n_valid), 32'd1);
        check_val("nack_ntx", 32'(tx_log.size()), 32'd6);
        check_val("nack_tx2", 32'(tx_log[2]), 32'h001);
        check_val("nack_tx3", 32'(tx_log[3]), 32'h007);
        check_val("nack_tx4", 32'(tx_log[4]), 32'h010);
        check_val("nack_backoff", 32'(tx_det[2] - tx_done[1]), 32'd22);
        check_val("nack_err_seen", 32'(err_seen), 32'h1);
        check_val("nack_err_clr", 32'(err), 32'h0);
        check_val("nack_lux", 32'(lux_raw), 32'h5678);

        // reset while a read is in flight
        rd_val = 16'h1111;
        for (int i = 0; i < 200 && !(i2c_req && i2c_rd); i++) begin
            @(posedge clk_in); #2;
        end
        check_val("mid_rd_req", 32'(i2c_req && i2c_rd), 32'h1);
        rst_in = 1'b1;
        #1;
        check_val("mid_req", 32'(i2c_req), 32'h0);
        check_val("mid_lux", 32'(lux_raw), 32'h0);
        check_val("mid_valid", 32'(lux_valid), 32'h0);
        check_val("mid_busy", 32'(busy), 32'h0);
        hold_reset(1'b1);
        for (int i = 0; i < 100 && tx_log.size() < 1; i++) begin
            @(posedge clk_in); #2;
        end
        check_val("mid_tx0", 32'(tx_log[0]), 32'h001);
        check_val("mid_restart_lat", 32'(tx_det[0] - rel_cyc), 32'd11);

        // cont_mode 1->0 during WAIT_MEAS
        rd_val = 16'h2222;
        hold_reset(1'b1);
        for (int i = 0; i < 600 && n_valid < 1; i++) begin
            @(posedge clk_in); #2;
        end
        cont_mode = 1'b0;
        rd_val    = 16'h3333;
        for (int i = 0; i < 300 && !(n_valid >= 2 && !busy); i++) begin
            @(posedge clk_in); #2;
        end
        repeat (50) @(posedge clk_in);
        #2;
        check_val("tog_nvalid", 32'(n_valid), 32'd2);
        check_val("tog_lux", 32'(lux_raw), 32'h3333);
        check_val("tog_busy", 32'(busy), 32'h0);
        check_val("tog_ntx", 32'(tx_log.size()), 32'd5);
        rd_val = 16'h4444;
        pulse_start();
        for (int i = 0; i < 300 && !(n_valid >= 3 && !busy); i++) begin
            @(posedge clk_in); #2;
        end
        check_val("tog_ntx2", 32'(tx_log.size()), 32'd7);
        check_val("tog_tx5", 32'(tx_log[5]), 32'h020);
        check_val("tog_lux2", 32'(lux_raw), 32'h4444);
        check_val("valid_width", 32'(multi_v), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
